// File: rtl/periph_irq_ctrl.sv
// periph_irq_ctrl
// Interrupt controller for the SPI / UART-rx / I2C completion flags.
// Rising edges on src are latched into pend, and a second edge on a bit
// that is still pending sets that bit's sticky ovf flag. Sources enabled in
// en compete for a single request line. The core claims a request with ack
// and releases it with eoi.
//
// Parameters:
//   RR        0 = fixed priority SPI > UART > I2C,
//             1 = round-robin (the last acked source becomes lowest priority)
// Ports:
//   clk       clock, rising edge
//   nrst      synchronous reset, active low
//   src[2:0]  level completion flags: [0] SPI, [1] UART rx, [2] I2C
//   cfg_we    configuration write strobe
//   cfg_wdata [2:0] enable mask, [5:3] overflow clear (write 1 to clear)
//   ack       core claims the current request
//   eoi       core has finished the handler
//   irq       interrupt request
//   irq_id    source of the current or serviced request, 3 = none
//   pend      pending flags
//   ovf       sticky overflow flags
//   en        current enable mask
module periph_irq_ctrl #(
    parameter int RR = 0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [2:0] src,
    input  logic       cfg_we,
    input  logic [7:0] cfg_wdata,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [1:0] irq_id,
    output logic [2:0] pend,
    output logic [2:0] ovf,
    output logic [2:0] en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t     state_reg;
    logic [2:0] src_q_reg;
    logic [2:0] pend_reg;
    logic [2:0] ovf_reg;
    logic [2:0] en_reg;
    logic       irq_reg;
    logic [1:0] irq_id_reg;
    logic [1:0] rr_ptr_reg;

    logic [2:0] event_vec;
    logic [2:0] cand;
    logic [2:0] id_onehot;
    logic [2:0] ack_clr;
    logic [2:0] ovf_set;
    logic [2:0] pend_next;
    logic [2:0] ovf_next;
    logic       en_cur;
    logic [1:0] prio_start;
    logic [1:0] slot [3];
    logic [1:0] grant_id;

    // Bits [7:6] of the config word carry no function.
    logic unused_cfg_bits;
    assign unused_cfg_bits = &{1'b0, cfg_wdata[7:6]};

    // (s + k) mod 3 for s, k in 0..2
    function automatic logic [1:0] rot3(input logic [1:0] s, input logic [1:0] k);
        logic [2:0] t;
        t = {1'b0, s} + {1'b0, k};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

    assign event_vec = src & ~src_q_reg;
    assign cand      = pend_reg & en_reg;
    assign ack_clr   = id_onehot & {3{(state_reg == REQ) && ack}};
    assign en_cur    = |(en_reg & id_onehot);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            assign id_onehot[gi] = (irq_id_reg == 2'(gi));
            // An edge on the same cycle as the ack re-arms the bit instead
            // of being counted as an overflow.
            assign ovf_set[gi]   = event_vec[gi] & pend_reg[gi] & ~ack_clr[gi];
            assign pend_next[gi] = event_vec[gi] | (pend_reg[gi] & ~ack_clr[gi]);
            // A new overflow outranks a simultaneous software clear.
            assign ovf_next[gi]  = ovf_set[gi] |
                                   (ovf_reg[gi] & ~(cfg_we & cfg_wdata[3 + gi]));
        end
    endgenerate

    // Priority order: slot[0] is highest. In round-robin mode the order
    // starts just after the most recently acked source.
    assign prio_start = (RR != 0) ? rot3(rr_ptr_reg, 2'd1) : 2'd0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            assign slot[gi] = rot3(prio_start, 2'(gi));
        end
    endgenerate

    always_comb begin
        grant_id = 2'd3;
        if (cand[slot[0]]) begin
            grant_id = slot[0];
        end else if (cand[slot[1]]) begin
            grant_id = slot[1];
        end else if (cand[slot[2]]) begin
            grant_id = slot[2];
        end
    end

    // Flag and configuration registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            src_q_reg <= 3'b000;
            pend_reg  <= 3'b000;
            ovf_reg   <= 3'b000;
            en_reg    <= 3'b000;
        end else begin
            src_q_reg <= src;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            if (cfg_we) begin
                en_reg <= cfg_wdata[2:0];
            end
        end
    end

    // Request state machine with registered irq / irq_id
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= IDLE;
            irq_reg    <= 1'b0;
            irq_id_reg <= 2'd3;
            rr_ptr_reg <= 2'd2;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|cand) begin
                        state_reg  <= REQ;
                        irq_reg    <= 1'b1;
                        irq_id_reg <= grant_id;
                    end
                end
                REQ: begin
                    // ack wins over eoi and over a simultaneous withdraw.
                    if (ack) begin
                        state_reg <= SVC;
                        irq_reg   <= 1'b0;
                        if (RR != 0) begin
                            rr_ptr_reg <= irq_id_reg;
                        end
                    end else if (!en_cur) begin
                        // Masked before being claimed; pend is kept.
                        state_reg  <= IDLE;
                        irq_reg    <= 1'b0;
                        irq_id_reg <= 2'd3;
                    end
                end
                SVC: begin
                    if (eoi) begin
                        state_reg  <= IDLE;
                        irq_id_reg <= 2'd3;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    irq_reg    <= 1'b0;
                    irq_id_reg <= 2'd3;
                end
            endcase
        end
    end

    assign irq    = irq_reg;
    assign irq_id = irq_id_reg;
    assign pend   = pend_reg;
    assign ovf    = ovf_reg;
    assign en     = en_reg;

endmodule
